riscv_imem_rsp: RTL and testbench

Instruction-memory responder for the NPC core: it sits at the far end of the fetch address bus driven by the PC/next-PC logic. It accepts one fetch request at a time over a valid/ready handshake, holds it for a configurable access latency, and returns the 32-bit instruction word or an access error. A word-wide load port lets the testbench or loader preload program images.

---
 rtl/riscv_imem_rsp_if.sv | 27 ++
 rtl/riscv_imem_rsp.sv | 120 ++++++++++++
 tb/tb_riscv_imem_rsp.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_imem_rsp_if.sv
// Fetch request/response and preload bus between the fetch unit (master) and riscv_imem_rsp (slave).
// Signal names carry the responder-side direction suffixes.
interface riscv_imem_rsp_if #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 10
);
  logic                  req_valid_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic                  req_ready_o;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [31:0]           rsp_inst_o;
  logic                  rsp_err_o;
  logic                  ld_en_i;
  logic [DEPTH_LOG2-1:0] ld_idx_i;
  logic [31:0]           ld_data_i;

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i, ld_en_i, ld_idx_i, ld_data_i,
    input  req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i, ld_en_i, ld_idx_i, ld_data_i,
    output req_ready_o, rsp_valid_o, rsp_inst_o, rsp_err_o
  );
endinterface

// File: rtl/riscv_imem_rsp.sv
// Instruction-memory responder: one fetch in flight, fixed access latency, word preload port.
// Optional macro IMEM_BACK2BACK_EN lets a new request be accepted in the cycle the response is taken.
module riscv_imem_rsp #(
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                LATENCY    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_imem_rsp_if.slave      bus,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens at a rising edge where valid && ready. The requester holds
  // req_valid_i/req_addr_i until accepted; rsp_* stay constant while rsp_valid_o && !rsp_ready_i.

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam int              DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + ((ADDR_W+1)'(DEPTH) << 2);
  localparam logic [3:0]      LAT_M1   = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  rsp_valid, valid_nxt;
  logic [31:0]           rsp_inst;
  logic                  rsp_err;
  logic                  req_ready;
  logic                  accept;
  logic [ADDR_W-1:0]     offset;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  addr_err;

  assign offset   = bus.req_addr_i - BASE_ADDR;
  assign rd_idx   = offset[DEPTH_LOG2+1:2];
  // Compare against the end address one bit wider so a window ending at 2^ADDR_W does not wrap.
  assign addr_err = (bus.req_addr_i[1:0] != 2'b00) ||
                    (bus.req_addr_i < BASE_ADDR) ||
                    ({1'b0, bus.req_addr_i} >= END_ADDR);

  always_comb begin
    req_ready = (state == IDLE);
`ifdef IMEM_BACK2BACK_EN
    if (state == RESP) req_ready = bus.rsp_ready_i;
`endif
  end

  assign accept          = bus.req_valid_i && req_ready;
  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_inst_o  = rsp_inst;
  assign bus.rsp_err_o   = rsp_err;
  assign dbg_state       = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    valid_nxt = rsp_valid;
    case (state)
      IDLE: ;
      WAIT: begin
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          valid_nxt = 1'b1;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    // Accept is only possible from IDLE or from a RESP that is being drained this cycle.
    if (accept) begin
      if (LATENCY == 1) begin
        state_nxt = RESP;
        valid_nxt = 1'b1;
      end else begin
        state_nxt = WAIT;
        cnt_nxt   = LAT_M1;
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_inst  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_valid <= valid_nxt;
      if (accept) begin
        rsp_err  <= addr_err;
        rsp_inst <= addr_err ? 32'd0 : mem[rd_idx];
      end
    end
  end

  // Array is not reset; a same-edge preload to the fetched word lands after the capture above.
  always_ff @(posedge clk) begin
    if (bus.ld_en_i) mem[bus.ld_idx_i] <= bus.ld_data_i;
  end

endmodule

// File: tb/tb_riscv_imem_rsp.sv
// Directed bench for riscv_imem_rsp (LATENCY=2, DEPTH_LOG2=10, BASE_ADDR=0).
// Build with or without IMEM_BACK2BACK_EN; the streaming period expectation follows the macro.
module tb_riscv_imem_rsp;

  localparam int ADDR_W     = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 2;
`ifdef IMEM_BACK2BACK_EN
  localparam int STREAM_PERIOD = LATENCY;
`else
  localparam int STREAM_PERIOD = LATENCY + 1;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  riscv_imem_rsp_if #(.ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  riscv_imem_rsp #(
    .ADDR_W    (ADDR_W),
    .DEPTH_LOG2(DEPTH_LOG2),
    .BASE_ADDR (32'h0000_0000),
    .LATENCY   (LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: expected {err, inst}
  logic [32:0] exp_q[$];
  int          take_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: a response is taken at the next rising edge when valid && ready at the falling edge
  always @(negedge clk) begin
    if (bus.rsp_valid_o && bus.rsp_ready_i) begin
      take_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp_unexpected: actual err=%0b inst=%h required=no response",
                 bus.rsp_err_o, bus.rsp_inst_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_data", {31'd0, bus.rsp_err_o, bus.rsp_inst_o}, {31'd0, e});
      end
    end
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic load(input logic [DEPTH_LOG2-1:0] idx, input logic [31:0] data);
    bus.ld_en_i   = 1'b1;
    bus.ld_idx_i  = idx;
    bus.ld_data_i = data;
    @(posedge clk); #1;
    bus.ld_en_i = 1'b0;
  endtask

  task automatic issue(input logic [31:0] addr, input logic [32:0] exp, input bit push,
                       input bit do_ld, input logic [DEPTH_LOG2-1:0] idx, input logic [31:0] data);
    bit got = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    if (do_ld) begin
      bus.ld_en_i   = 1'b1;
      bus.ld_idx_i  = idx;
      bus.ld_data_i = data;
    end
    repeat (50) begin
      @(negedge clk);
      if (bus.req_ready_o) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.ld_en_i     = 1'b0;
    if (got && push) exp_q.push_back(exp);
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL req_accept_timeout: actual=not accepted required=accepted addr=%h", addr);
    end
  endtask

  task automatic wait_drain(input string name);
    repeat (60) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.rsp_valid_o) break;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.rsp_ready_i = 1'b1;
    bus.ld_en_i     = 1'b0;
    bus.ld_idx_i    = '0;
    bus.ld_data_i   = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // preload program image, then reset mid-cycle; the array survives reset
    load(10'd0,    32'h0000_0413);
    load(10'd1,    32'h0010_0093);
    load(10'd2,    32'h0020_0113);
    load(10'd3,    32'h0030_0193);
    load(10'd1023, 32'h0000_006f);
    #3 rst = 1'b1;
    @(negedge clk);
    check("reset_outputs", {60'd0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, 1'b0}, {60'd0, 4'b1000});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {29'd0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_inst_o},
          {29'd0, 3'b100, 32'd0});
    @(posedge clk); #1;

    // basic fetch with latency check
    issue(32'h0, {1'b0, 32'h0000_0413}, 1'b1, 1'b0, '0, '0);
    @(negedge clk);
    check("latency_e1_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    @(negedge clk);
    check("latency_e2_valid", {63'd0, bus.rsp_valid_o}, 64'd1);
    @(posedge clk); #1;
    wait_drain("drain_basic");

    // backpressure: response held stable for 5 cycles
    bus.rsp_ready_i = 1'b0;
    issue(32'h4, {1'b0, 32'h0010_0093}, 1'b1, 1'b0, '0, '0);
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid_o) break;
    end
    for (int i = 0; i < 5; i++) begin
      check("backpressure_hold", {29'd0, bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_inst_o},
            {29'd0, 3'b010, 32'h0010_0093});
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_take", {62'd0, bus.req_ready_o, bus.rsp_valid_o}, {62'd0, 2'b10});
    @(posedge clk); #1;
    wait_drain("drain_backpressure");

    // access errors and the last legal word
    issue(32'h2,    {1'b1, 32'h0},          1'b1, 1'b0, '0, '0);
    wait_drain("drain_misaligned");
    issue(32'h1000, {1'b1, 32'h0},          1'b1, 1'b0, '0, '0);
    wait_drain("drain_out_of_range");
    issue(32'hFFC,  {1'b0, 32'h0000_006f}, 1'b1, 1'b0, '0, '0);
    wait_drain("drain_last_word");

    // same-cycle preload and accept returns old data; later writes do not disturb in-flight data
    issue(32'h8, {1'b0, 32'h0020_0113}, 1'b1, 1'b1, 10'd2, 32'hDEAD_BEEF);
    wait_drain("drain_rbw");
    issue(32'h8, {1'b0, 32'hDEAD_BEEF}, 1'b1, 1'b0, '0, '0);
    load(10'd2, 32'hCAFE_F00D);
    wait_drain("drain_inflight_write");
    issue(32'h8, {1'b0, 32'hCAFE_F00D}, 1'b1, 1'b0, '0, '0);
    wait_drain("drain_after_write");

    // streaming sequential fetches with rsp_ready_i held high
    take_q.delete();
    issue(32'h0, {1'b0, 32'h0000_0413}, 1'b1, 1'b0, '0, '0);
    issue(32'h4, {1'b0, 32'h0010_0093}, 1'b1, 1'b0, '0, '0);
    issue(32'h8, {1'b0, 32'hCAFE_F00D}, 1'b1, 1'b0, '0, '0);
    issue(32'hC, {1'b0, 32'h0030_0193}, 1'b1, 1'b0, '0, '0);
    wait_drain("drain_stream");
    check("stream_count", 64'(take_q.size()), 64'd4);
    if (take_q.size() == 4) begin
      for (int i = 1; i < 4; i++) check("stream_period", 64'(take_q[i] - take_q[i-1]), 64'(STREAM_PERIOD));
    end

    // reset while waiting: the aborted fetch never responds
    issue(32'h0, {1'b0, 32'h0}, 1'b0, 1'b0, '0, '0);
    #2 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_wait_no_valid", {63'd0, bus.rsp_valid_o}, 64'd0);
    end
    @(posedge clk); #1;
    issue(32'hC, {1'b0, 32'h0030_0193}, 1'b1, 1'b0, '0, '0);
    wait_drain("drain_recovery");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
